uart_msg_scheduler: RTL

- Shares one ROM string table and one simpleUARTtx between N_REQ message requesters (buttons, timer, status events).
- Latches request pulses and picks a requester round-robin.
- For the granted requester, walks the ROM from that requester's base address and hands each byte to the UART via the start/busy handshake. Stops at the null terminator or at MAX_LEN bytes.
- Sits between the requesters, the ROM (addr/data) and the UART; replaces the single-source fsm.

---
 rtl/uart_msg_scheduler_pkg.sv | 25 ++
 rtl/uart_msg_scheduler_rr_arbiter.sv | 73 +++++++
 rtl/uart_msg_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// uart_msg_scheduler_pkg
// Shared definitions for the UART message scheduler: the FSM state encoding,
// the string terminator value and a helper that sizes requester index fields.
// -----------------------------------------------------------------------------
package uart_msg_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_CHECK = 3'd2,
      ST_START = 3'd3,
      ST_WAIT  = 3'd4,
      ST_END   = 3'd5
   } state_e;

   // String terminator stored in the ROM
   localparam logic [7:0] NUL_BYTE = 8'h00;

   // Width of an index into n requesters (at least one bit)
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_msg_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin pick among N requesters. The pick is combinational from pend_i
// and the pointer; the pointer moves past the winner when adv_i is asserted.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   pend_i       : pending request vector
//   adv_i        : winner is being granted this cycle, advance the pointer
//   valid_o      : at least one request pending
//   idx_o        : index of the winner
//   gnt_o        : one-hot winner (all zero when nothing pending)
// -----------------------------------------------------------------------------
module rr_arbiter
   import uart_msg_scheduler_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = idx_width(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  pend_i,
   input  logic          adv_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o,
   output logic [N-1:0]  gnt_o
);

   logic [IW-1:0] ptr_q;
   logic [IW-1:0] ptr_d;
   logic [IW-1:0] idx_s;
   logic          valid_s;
   logic [N-1:0]  gnt_s;

   // Scan downward from the farthest slot so the nearest pending slot to the
   // pointer is the last one written and therefore wins.
   always_comb begin
      int  pos;
      logic hit;
      valid_s = 1'b0;
      idx_s   = '0;
      pos     = 0;
      hit     = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         pos     = (int'(ptr_q) + k >= N) ? int'(ptr_q) + k - N : int'(ptr_q) + k;
         hit     = pend_i[pos];
         idx_s   = hit ? IW'(pos) : idx_s;
         valid_s = valid_s | hit;
      end
   end

   // One-hot form of the winner and next pointer (slot after the winner)
   always_comb begin
      for (int i = 0; i < N; i++) begin
         gnt_s[i] = valid_s && (int'(idx_s) == i);
      end
      ptr_d = (int'(idx_s) == N - 1) ? '0 : idx_s + 1'b1;
   end

   // Pointer register, only moves when a grant is actually taken
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else if (adv_i && valid_s) begin
         ptr_q <= ptr_d;
      end else begin
         ptr_q <= ptr_q;
      end
   end

   assign valid_o = valid_s;
   assign idx_o   = idx_s;
   assign gnt_o   = gnt_s;

endmodule

// File: rtl/uart_msg_scheduler.sv
// -----------------------------------------------------------------------------
// uart_msg_scheduler
// Shares one ROM string table and one UART transmitter between N_REQ message
// requesters. Request edges are latched, a requester is chosen round-robin and
// its string is walked from its base address, one byte per UART start/busy
// handshake, until a NUL byte or MAX_LEN bytes.
//   clk_i        : system clock
//   rst_i        : asynchronous active-high reset
//   req_i        : request pulses, one bit per requester
//   base_addr_i  : per-requester string start address, sampled at grant
//   address_o    : ROM address
//   byte_i       : ROM data, valid one cycle after address_o changes
//   start_o      : UART start request
//   busy_i       : UART busy, asynchronous to clk_i
//   grant_o      : one-hot requester being served
//   done_o       : one-cycle pulse at message end
//   trunc_o      : with done_o when the message hit MAX_LEN
//   err_o        : one-cycle pulse when the UART never answered start_o
// -----------------------------------------------------------------------------
module uart_msg_scheduler
   import uart_msg_scheduler_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int ADDR_W   = 4,
   parameter int MAX_LEN  = 16,
   parameter int START_TO = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_REQ-1:0]        req_i,
   input  logic [N_REQ*ADDR_W-1:0] base_addr_i,
   output logic [ADDR_W-1:0]       address_o,
   input  logic [7:0]              byte_i,
   output logic                    start_o,
   input  logic                    busy_i,
   output logic [N_REQ-1:0]        grant_o,
   output logic                    done_o,
   output logic                    trunc_o,
   output logic                    err_o
);

   localparam int IW    = idx_width(N_REQ);
   localparam int CNT_W = $clog2(MAX_LEN + 1);
   localparam int TMR_W = (START_TO > 1) ? $clog2(START_TO + 1) : 1;

   state_e             state_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               start_q;
   logic [N_REQ-1:0]   grant_q;
   logic               done_q;
   logic               trunc_q;
   logic               err_q;
   logic               trunc_pend_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [TMR_W-1:0]   tmr_q;

   logic               busy_meta_q;
   logic               busy_s_q;
   logic [N_REQ-1:0]   req_q;
   logic [N_REQ-1:0]   pend_q;
   logic [N_REQ-1:0]   pend_d;

   logic               arb_valid_s;
   logic [IW-1:0]      arb_idx_s;
   logic [N_REQ-1:0]   arb_gnt_s;
   logic               arb_adv_s;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pend_i  (pend_q),
      .adv_i   (arb_adv_s),
      .valid_o (arb_valid_s),
      .idx_o   (arb_idx_s),
      .gnt_o   (arb_gnt_s)
   );

   assign arb_adv_s = (state_q == ST_IDLE) && arb_valid_s;

   // Clearing the granted bit and setting a fresh edge in the same cycle keeps
   // the new request queued rather than losing it.
   always_comb begin
      pend_d = (pend_q & ~(arb_adv_s ? arb_gnt_s : {N_REQ{1'b0}})) | (req_i & ~req_q);
   end

   // Busy synchroniser, request edge detector and pending latches
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_meta_q <= 1'b0;
         busy_s_q    <= 1'b0;
         req_q       <= '0;
         pend_q      <= '0;
      end else begin
         busy_meta_q <= busy_i;
         busy_s_q    <= busy_meta_q;
         req_q       <= req_i;
         pend_q      <= pend_d;
      end
   end

   // Message FSM with registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         start_q      <= 1'b0;
         grant_q      <= '0;
         done_q       <= 1'b0;
         trunc_q      <= 1'b0;
         err_q        <= 1'b0;
         trunc_pend_q <= 1'b0;
         cnt_q        <= '0;
         tmr_q        <= '0;
      end else begin
         done_q  <= 1'b0;
         trunc_q <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid_s) begin
                  grant_q      <= arb_gnt_s;
                  addr_q       <= base_addr_i[int'(arb_idx_s)*ADDR_W +: ADDR_W];
                  cnt_q        <= '0;
                  trunc_pend_q <= 1'b0;
                  state_q      <= ST_FETCH;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            // ROM data for the new address lands at the end of this cycle
            ST_FETCH: begin
               state_q <= ST_CHECK;
            end
            ST_CHECK: begin
               if (byte_i == NUL_BYTE) begin
                  state_q <= ST_END;
               end else begin
                  start_q <= 1'b1;
                  tmr_q   <= '0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (busy_s_q) begin
                  start_q <= 1'b0;
                  state_q <= ST_WAIT;
               end else if (tmr_q == TMR_W'(START_TO - 1)) begin
                  // UART never responded: abandon the message
                  start_q <= 1'b0;
                  err_q   <= 1'b1;
                  grant_q <= '0;
                  state_q <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            ST_WAIT: begin
               if (!busy_s_q) begin
                  cnt_q  <= cnt_q + 1'b1;
                  addr_q <= addr_q + 1'b1;
                  if (cnt_q == CNT_W'(MAX_LEN - 1)) begin
                     trunc_pend_q <= 1'b1;
                     state_q      <= ST_END;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_END: begin
               done_q  <= 1'b1;
               trunc_q <= trunc_pend_q;
               grant_q <= '0;
               state_q <= ST_IDLE;
            end
            default: begin
               start_q <= 1'b0;
               grant_q <= '0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign address_o = addr_q;
   assign start_o   = start_q;
   assign grant_o   = grant_q;
   assign done_o    = done_q;
   assign trunc_o   = trunc_q;
   assign err_o     = err_q;

endmodule
